// File: rtl/tts_pkg.sv
// Shared types, constants and the vector-order function for the truth-table sequencer.
// TTS_GRAY_ORDER_EN selects Gray-code sweep order; otherwise binary order.
package tts_pkg;

   localparam int DEF_N_IN   = 3;
   localparam int DEF_SETTLE = 2;
   localparam int TBL_W      = 2**DEF_N_IN;
   localparam int CNT_W      = DEF_N_IN + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tts_state_e;

   // Maps sweep step k to the stimulus vector applied at that step.
   function automatic logic [15:0] vec_order(input logic [15:0] k);
`ifdef TTS_GRAY_ORDER_EN
      return k ^ (k >> 1);
`else
      return k;
`endif
   endfunction

endpackage

// File: rtl/tts_result_acc.sv
// Observed-table writer and mismatch accumulator; cleared on start, updated in SAMPLE.
module tts_result_acc
   import tts_pkg::*;
#(
   parameter int N_IN = DEF_N_IN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 en,
   input  logic [N_IN-1:0]      idx,
   input  logic                 f_i,
   input  logic                 exp_bit,
   output logic [2**N_IN-1:0]   table_o,
   output logic [N_IN:0]        mismatch_cnt_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 2**N_IN; gi++) begin : g_tbl
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               table_o[gi] <= 1'b0;
            end else if (clear) begin
               table_o[gi] <= 1'b0;
            end else if (en && (idx == N_IN'(gi))) begin
               table_o[gi] <= f_i;
            end
         end
      end
   endgenerate

   // At most 2**N_IN increments per sweep, so N_IN+1 bits never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_cnt_o <= '0;
      end else if (clear) begin
         mismatch_cnt_o <= '0;
      end else if (en && (f_i != exp_bit)) begin
         mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-timed sweep of a combinational block's inputs, building and checking its truth table.
// Sweep order follows TTS_GRAY_ORDER_EN (Gray) or binary when undefined.
module truth_table_sequencer
   import tts_pkg::*;
#(
   parameter int N_IN          = DEF_N_IN,
   parameter int SETTLE_CYCLES = DEF_SETTLE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected_i,
   input  logic                 f_i,
   output logic [N_IN-1:0]      stim_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2**N_IN-1:0]   table_o,
   output logic [N_IN:0]        mismatch_cnt_o,
   output logic                 pass_o
);

   tts_state_e            state_reg, state_next;
   logic [N_IN-1:0]       step_reg;
   logic [7:0]            cnt_reg;
   logic [2**N_IN-1:0]    exp_reg;
   logic                  pass_reg;
   logic [N_IN-1:0]       stim_reg;
   logic [15:0]           vec_first, vec_next;
   logic                  start_acc, last_step, settle_end;

   assign start_acc  = (state_reg == IDLE) && start;
   assign last_step  = &step_reg;
   assign settle_end = (cnt_reg == 8'(SETTLE_CYCLES - 1));
   assign vec_first  = vec_order(16'd0);
   assign vec_next   = vec_order(16'(step_reg) + 16'd1);
   assign stim_o     = stim_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_reg  <= '0;
         step_reg <= '0;
         stim_reg <= '0;
         cnt_reg  <= '0;
         pass_reg <= 1'b0;
      end else if (start_acc) begin
         exp_reg  <= expected_i;
         step_reg <= '0;
         stim_reg <= vec_first[N_IN-1:0];
         cnt_reg  <= '0;
         pass_reg <= 1'b0;
      end else begin
         case (state_reg)
            SETTLE: cnt_reg <= cnt_reg + 8'd1;
            SAMPLE: begin
               if (!last_step) begin
                  step_reg <= step_reg + 1'b1;
                  stim_reg <= vec_next[N_IN-1:0];
                  cnt_reg  <= '0;
               end
            end
            DONE:    pass_reg <= (mismatch_cnt_o == '0);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SETTLE;
         SETTLE:  if (settle_end) state_next = SAMPLE;
         SAMPLE:  state_next = last_step ? DONE : SETTLE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // pass_o tracks the live count during DONE, then holds the latched verdict.
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      pass_o = pass_reg;
      case (state_reg)
         SETTLE, SAMPLE: busy_o = 1'b1;
         DONE: begin
            done_o = 1'b1;
            pass_o = (mismatch_cnt_o == '0);
         end
         default: ;
      endcase
   end

   tts_result_acc #(.N_IN(N_IN)) u_acc (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (start_acc),
      .en             (state_reg == SAMPLE),
      .idx            (stim_reg),
      .f_i            (f_i),
      .exp_bit        (exp_reg[stim_reg]),
      .table_o        (table_o),
      .mismatch_cnt_o (mismatch_cnt_o)
   );

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequences a 3-input combinational logic block (inputs A, B, C; output F) through every input combination.
- Samples F after a programmable settle time, builds the observed truth table, compares it against an expected table, and reports pass/fail.
- Sits between a test/config host and the combinational block. It replaces hand-stepped stimulus with a self-timed sweep.

Parameters:
- N_IN, 3, number of DUT inputs; table width is 2**N_IN.
- SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; honoured only in IDLE.
- expected_i  input  2**N_IN  expected truth table, bit i = F for input vector i; captured on the accepted start.
- f_i  input  1  output F of the combinational block.
- stim_o  output  N_IN  drives the DUT inputs; stim_o[N_IN-1]=A, stim_o[N_IN-2]=B, stim_o[0]=C.
- busy_o  output  1  high from the cycle after an accepted start until done_o.
- done_o  output  1  one-cycle pulse when the sweep completes.
- table_o  output  2**N_IN  observed truth table; bit i = F sampled with stim_o == i.
- mismatch_cnt_o  output  N_IN+1  popcount(table_o ^ expected).
- pass_o  output  1  high when mismatch_cnt_o == 0; valid only after done_o.

Behaviour:
- Reset values (async, rst_n low):
  - state IDLE
  - stim_o = 0, table_o = 0, mismatch_cnt_o = 0
  - busy_o = 0, done_o = 0, pass_o = 0
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → SETTLE.
  - Same edge: capture expected_i, load step index = 0, stim_o = vector(0), clear table_o, mismatch_cnt_o and pass_o, settle counter = 0.
- SETTLE:
  - stim_o held stable; counter increments each cycle.
  - When counter == SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (exactly one cycle):
  - On the exit edge: table_o[stim_o] <= f_i; mismatch_cnt_o += (f_i != expected[stim_o]).
  - If step index == 2**N_IN-1 → DONE.
  - Otherwise increment step index, stim_o = vector(step+1), counter = 0, → SETTLE.
- DONE (one cycle):
  - done_o=1, busy_o=0, pass_o=(mismatch_cnt_o==0).
  - → IDLE.
- Latency: with start accepted in cycle 0, done_o is high in cycle 1 + 2**N_IN*(SETTLE_CYCLES+1). Default values give cycle 25.
- Results (table_o, mismatch_cnt_o, pass_o) hold after DONE until the next accepted start.
- start while busy, or in DONE, is ignored (not queued).
- start held high continuously: a new sweep begins the cycle after DONE.
- rst_n low mid-sweep: immediate return to reset values; the partial table is discarded.
- f_i is sampled only in SAMPLE; glitches during SETTLE are ignored.
- mismatch_cnt_o cannot overflow: maximum value is 2**N_IN, which fits in N_IN+1 bits.

Optional Feature:
- Macro: TTS_GRAY_ORDER_EN.
- Defined: vector(k) = k ^ (k>>1), so exactly one input toggles per step (order 0,1,3,2,6,7,5,4 for N_IN=3).
- Not defined: vector(k) = k (binary order).
- table_o is always indexed by stim_o value, so results are identical in both modes.

Decomposition:
- Shared package tts_pkg holds:
  - the state enum typedef (IDLE/SETTLE/SAMPLE/DONE)
  - constants TBL_W = 2**N_IN and CNT_W = N_IN+1
  - the vector-order function
- One natural sub-module: tts_result_acc, which does the table write and mismatch accumulation, clears on start, and is enabled in SAMPLE.

Test Plan:
- Reset mid-sweep: assert rst_n=0 at cycle 10 → all outputs zero immediately. A new start then yields a full 25-cycle sweep.
- Correct DUT: model F=(A&~B)|C, expected_i=8'hBA, start pulse → done_o in cycle 25, table_o=8'hBA, mismatch_cnt_o=0, pass_o=1.
- Wrong expectation: same DUT, expected_i=8'hBB → table_o=8'hBA, mismatch_cnt_o=1, pass_o=0.
- Start while busy: second start pulse at cycle 7 → ignored; single done_o pulse at cycle 25; busy_o stays high over cycles 1..24.
- Stimulus timing: SETTLE_CYCLES=1 → stim_o changes every 2 cycles; done_o in cycle 17. With TTS_GRAY_ORDER_EN, stim_o sequence is 0,1,3,2,6,7,5,4 and table_o is still 8'hBA.
- Constant DUT: f_i tied to 0, expected_i=8'hFF → mismatch_cnt_o=8, pass_o=0, table_o=8'h00.
